// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding and the
// default SRAM geometry/timing reused by the controller and the SRAM model.
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SRAM_DW     = 16;
  localparam int DEF_SRAM_AW     = 18;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 5;

  function automatic int beats_of(input int data_w, input int sram_dw);
    return data_w / sram_dw;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Modulo-WAIT_CYCLES counter timing one SRAM beat; tc marks the last cycle of the beat.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage memory controller: splits one DATA_W word access into BEATS
// little-endian SRAM beats of WAIT_CYCLES each, holding ready low meanwhile.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SRAM_DW     = DEF_SRAM_DW,
  parameter int SRAM_AW     = DEF_SRAM_AW,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output state_t             dbg_state
);

  localparam int BEATS  = beats_of(DATA_W, SRAM_DW);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                is_wr_q;
  logic                req;
  logic                wait_clr;
  logic                wait_en;
  logic                wait_tc;
  logic [31:0]         word_idx;
  logic [SRAM_AW-1:0]  sram_base;

  // Handshake: the pipeline holds rd_en/wr_en (and address/data) stable until it
  // sees ready=1; ready is high in DONE, or in IDLE when nothing is requested,
  // and the pipeline advances on the edge where ready=1.
  assign req       = rd_en | wr_en;
  assign word_idx  = (addr_q - 32'(BASE_ADDR)) >> 2;
  assign sram_base = SRAM_AW'(word_idx * 32'(BEATS));
  assign wait_clr  = (state == IDLE);
  assign wait_en   = (state == ACCESS);
  assign dbg_state = state;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .en  (wait_en),
    .tc  (wait_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= write_data;
            is_wr_q <= wr_en;
            beat    <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_tc) begin
            if (!is_wr_q) begin
              read_data[int'(beat)*SRAM_DW +: SRAM_DW] <= sram_dq_in;
            end
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset releases the bus at once.
  always_comb begin
    ready       = ((state == IDLE) && !req) || (state == DONE);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == ACCESS) begin
      sram_addr = sram_base + SRAM_AW'(beat);
      if (is_wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = wdata_q[int'(beat)*SRAM_DW +: SRAM_DW];
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: 16-bit SRAM model with fixed read latency,
// plus a single-beat 32-bit instance.
module tb_sram_mem_controller;
  import sram_mem_controller_pkg::*;

  localparam int WAIT = DEF_WAIT_CYCLES;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
  state_t      dbg_state;

  sram_mem_controller dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .dbg_state   (dbg_state)
  );

  // 16-bit SRAM model: read data only valid once the address has been stable
  // for WAIT-1 cycles, garbage before that
  logic [15:0] mem [0:2**18-1];
  logic [17:0] last_addr = '1;
  int          age = 0;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    if (sram_addr == last_addr) age <= age + 1;
    else age <= 1;
    last_addr <= sram_addr;
  end

  always_comb begin
    sram_dq_in = 16'h0BAD;
    if (sram_addr == last_addr && age >= WAIT - 1) sram_dq_in = mem[sram_addr];
  end

  // single-beat instance
  logic        rd_en2, wr_en2;
  logic [31:0] address2, write_data2, read_data2;
  logic        ready2;
  logic [9:0]  sram_addr2;
  logic [31:0] sram_dq_out2, sram_dq_in2;
  logic        sram_dq_oe2, sram_we_n2;
  state_t      dbg_state2;

  sram_mem_controller #(
    .DATA_W      (32),
    .SRAM_DW     (32),
    .SRAM_AW     (10),
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (1)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en2),
    .wr_en       (wr_en2),
    .address     (address2),
    .write_data  (write_data2),
    .read_data   (read_data2),
    .ready       (ready2),
    .sram_addr   (sram_addr2),
    .sram_dq_out (sram_dq_out2),
    .sram_dq_in  (sram_dq_in2),
    .sram_dq_oe  (sram_dq_oe2),
    .sram_we_n   (sram_we_n2),
    .dbg_state   (dbg_state2)
  );

  logic [31:0] mem2 [0:1023];
  always @(posedge clk) begin
    if (!sram_we_n2) mem2[sram_addr2] <= sram_dq_out2;
  end
  always_comb sram_dq_in2 = mem2[sram_addr2];

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          lat, first_done, done_cyc;
  logic [17:0] addr_b0, addr_b1;
  logic        we_b0, oe_b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: called at a negedge; counts cycles from the IDLE cycle that sees the request
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int n);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    if (dbg_state != IDLE) @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        addr_b0 = sram_addr; we_b0 = sram_we_n; oe_b0 = sram_dq_oe;
      end
      if (n == WAIT + 1) addr_b1 = sram_addr;
    end while (!ready && n < 100);
    if (!ready) check("req_timeout", 32'(ready), 32'd1);
    done_cyc = cyc;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_req2(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int n);
    rd_en2 = rd; wr_en2 = wr; address2 = a; write_data2 = d;
    if (dbg_state2 != IDLE) @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready2 && n < 100);
    if (!ready2) check("req2_timeout", 32'(ready2), 32'd1);
    rd_en2 = 1'b0; wr_en2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd_en2 = 1'b0; wr_en2 = 1'b0; address2 = '0; write_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // write then read
    do_req(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, lat);
    check("wr_latency", 32'(lat), 32'd11);
    check("wr_we_n_b0", 32'(we_b0), 32'd0);
    check("wr_oe_b0", 32'(oe_b0), 32'd1);
    check("wr_addr_b0", 32'(addr_b0), 32'd0);
    check("wr_addr_b1", 32'(addr_b1), 32'd1);
    check("wr_mem0", 32'(mem[0]), 32'h0000_BEEF);
    check("wr_mem1", 32'(mem[1]), 32'h0000_DEAD);
    @(negedge clk);
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'd1024, 32'h0, lat);
    check("rd_latency", 32'(lat), 32'd11);
    check("rd_oe_b0", 32'(oe_b0), 32'd0);
    check("rd_data", read_data, exp_q.pop_front());

    // address map, including wrap below BASE_ADDR
    @(negedge clk);
    do_req(1'b0, 1'b1, 32'd1032, 32'h1111_2222, lat);
    check("map1032_b0", 32'(addr_b0), 32'd4);
    check("map1032_b1", 32'(addr_b1), 32'd5);
    do_req(1'b0, 1'b1, 32'd1020, 32'h3333_4444, lat);
    check("map1020_b0", 32'(addr_b0), 32'h3FFFE);
    check("map1020_b1", 32'(addr_b1), 32'h3FFFF);
    check("map1020_mem", 32'(mem[18'h3FFFF]), 32'h0000_3333);

    // back-to-back: read issued in the IDLE cycle right after the write's DONE
    @(negedge clk);
    do_req(1'b0, 1'b1, 32'd1028, 32'h0123_4567, lat);
    first_done = done_cyc;
    exp_q.push_back(32'h0123_4567);
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat);
    check("b2b_latency", 32'(lat), 32'd11);
    check("b2b_gap", 32'(done_cyc - first_done), 32'd12);
    check("b2b_data", read_data, exp_q.pop_front());

    // rd_en and wr_en together act as a write
    @(negedge clk);
    do_req(1'b1, 1'b1, 32'd1040, 32'hA5A5_5A5A, lat);
    check("both_rd_hold", read_data, 32'h0123_4567);
    check("both_mem8", 32'(mem[8]), 32'h0000_5A5A);
    check("both_mem9", 32'(mem[9]), 32'h0000_A5A5);
    exp_q.push_back(32'hA5A5_5A5A);
    do_req(1'b1, 1'b0, 32'd1040, 32'h0, lat);
    check("both_readback", read_data, exp_q.pop_front());

    // reset during beat 1 of a write
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFE_F00D;
    repeat (WAIT + 1) @(negedge clk);
    check("abort_pre_addr", 32'(sram_addr), 32'd1);
    check("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_mem1", 32'(mem[1]), 32'h0000_DEAD);
    check("abort_mem0", 32'(mem[0]), 32'h0000_F00D);
    check("abort_read_data", read_data, 32'h0);

    // single 32-bit beat, WAIT_CYCLES=1
    do_req2(1'b0, 1'b1, 32'd1028, 32'hFEED_F00D, lat);
    check("w1_wr_latency", 32'(lat), 32'd2);
    check("w1_mem", mem2[1], 32'hFEED_F00D);
    @(negedge clk);
    exp_q.push_back(32'hFEED_F00D);
    do_req2(1'b1, 1'b0, 32'd1028, 32'h0, lat);
    check("w1_rd_latency", 32'(lat), 32'd2);
    check("w1_rd_data", read_data2, exp_q.pop_front());

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
